// File: rtl/mem_burst_if.sv
// Burst command / data / memory-side signal bundle for mem_burst_ctrl.
//   slave  : view taken by the controller (accepts commands and write beats,
//            produces read beats, drives the memory address/enable/data).
//   master : view taken by whatever drives the controller and hosts the memory.
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len : burst command handshake
//   wr_valid/wr_ready/wr_data                      : write beat channel
//   rd_valid/rd_ready/rd_data/rd_last              : read beat channel
//   mem_addr/mem_we/mem_din/mem_dout               : single-port memory port
//   busy/done                                      : status
interface mem_burst_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
    output mem_addr, mem_we, mem_din, busy, done
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
    input  mem_addr, mem_we, mem_din, busy, done
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst front end for a single-port memory with a combinational read port.
// Accepts one burst command at a time, then streams write beats into the
// memory or read beats out of it with an auto-incrementing (wrapping) address.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active low (0 = reset)
//   bus : mem_burst_if.slave (command, write beat, read beat, memory port,
//         busy/done status)
module mem_burst_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_burst_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDRAIN} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic              done_q;

  logic              cmd_take;
  logic              wr_hs;
  logic              rd_load;
  logic              rd_drain;
  logic              last_beat;

  assign last_beat = (rem_q == '0);

  // Next state and per-cycle strobes
  always_comb begin
    state_d  = state;
    cmd_take = 1'b0;
    wr_hs    = 1'b0;
    rd_load  = 1'b0;
    rd_drain = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_take = 1'b1;
          state_d  = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          wr_hs = 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      READ: begin
        // The load condition already covers a consumed beat, so a handshake
        // here always refills the output register; it never empties in READ.
        if (!rd_valid_q || bus.rd_ready) begin
          rd_load = 1'b1;
          if (last_beat) state_d = RDRAIN;
        end
      end
      RDRAIN: begin
        if (rd_valid_q && bus.rd_ready) begin
          rd_drain = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered state, address/length counters and read output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= 1'b0;
      if (cmd_take) begin
        addr_q <= bus.cmd_addr;
        rem_q  <= bus.cmd_len;
      end
      if (wr_hs) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (last_beat) done_q <= 1'b1;
        else           rem_q  <= rem_q - LEN_W'(1);
      end
      if (rd_load) begin
        rd_data_q  <= bus.mem_dout;
        rd_valid_q <= 1'b1;
        rd_last_q  <= last_beat;
        addr_q     <= addr_q + ADDR_W'(1);
        rem_q      <= rem_q - LEN_W'(1);
      end
      if (rd_drain) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
        done_q     <= 1'b1;
      end
    end
  end

  // Handshake qualifiers are gated by rst so nothing is accepted and no
  // memory write happens on a reset edge, even mid-burst.
  assign bus.busy      = (state != IDLE);
  assign bus.cmd_ready = rst && (state == IDLE);
  assign bus.wr_ready  = rst && (state == WRITE);
  assign bus.mem_we    = rst && (state == WRITE) && bus.wr_valid;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = bus.wr_data;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  mem_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory attached to the controller
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  assign bus.mem_dout = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                last;
  } beat_t;

  beat_t             exp_wr[$];
  beat_t             exp_rd[$];
  logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];
  int                we_cnt = 0;
  int                done_cnt = 0;
  bit                m_busy = 0;
  bit                m_wr = 0;
  bit                m_done_next = 0;
  bit                hold = 0;
  logic [DATA_W-1:0] hold_data;

  function automatic logic [DATA_W-1:0] sh(input logic [ADDR_W-1:0] a);
    return shadow.exists(a) ? shadow[a] : '0;
  endfunction

  always @(negedge clk) begin
    beat_t b;
    chk("cmd_ready", bus.cmd_ready, rst && !m_busy);
    chk("busy", bus.busy, m_busy);
    chk("wr_ready", bus.wr_ready, rst && m_busy && m_wr);
    chk("mem_we", bus.mem_we, rst && m_busy && m_wr && bus.wr_valid);
    chk("done", bus.done, m_done_next);
    if (bus.done) done_cnt++;
    if (hold) begin
      chk("rd_hold_valid", bus.rd_valid, 1);
      chk("rd_hold_data", bus.rd_data, hold_data);
    end
    if (bus.rd_valid && exp_rd.size() == 0) chk("rd_spurious", 1, 0);
    m_done_next = 0;
    hold = 0;
    if (bus.mem_we) begin
      we_cnt++;
      if (exp_wr.size() == 0) chk("wr_spurious", 1, 0);
      else begin
        b = exp_wr.pop_front();
        chk("wr_addr", bus.mem_addr, b.addr);
        chk("wr_data", bus.mem_din, b.data);
        shadow[b.addr] = b.data;
        if (b.last) begin m_done_next = 1; m_busy = 0; end
      end
    end
    if (bus.rd_valid && bus.rd_ready && exp_rd.size() != 0) begin
      b = exp_rd.pop_front();
      chk("rd_data", bus.rd_data, b.data);
      chk("rd_last", bus.rd_last, b.last);
      if (b.last) begin m_done_next = 1; m_busy = 0; end
    end
    if (bus.rd_valid && !bus.rd_ready) begin
      hold = 1;
      hold_data = bus.rd_data;
    end
    if (rst && bus.cmd_valid && !m_busy) begin
      m_busy = 1;
      m_wr = bus.cmd_write;
    end
    if (!rst) begin
      exp_wr.delete();
      exp_rd.delete();
      m_busy = 0;
      m_wr = 0;
      m_done_next = 0;
      hold = 0;
    end
  end

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] wq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    bit hs;
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    do begin
      @(negedge clk);
      hs = bus.cmd_ready;
      step();
      n++;
    end while (!hs && n < 50);
    if (!hs) chk("cmd_timeout", 0, 1);
    bus.cmd_valid = 1'b0;
  endtask

  // Writes wq to address a; drops wr_valid for gap_len cycles after beat
  // gap_after; stops after stop_after beats, leaving the next beat offered.
  task automatic write_burst(input logic [ADDR_W-1:0] a, input int gap_after,
                             input int gap_len, input int stop_after);
    beat_t b;
    bit hs;
    int n;
    for (int i = 0; i < wq.size(); i++) begin
      b.addr = a + ADDR_W'(i);
      b.data = wq[i];
      b.last = (i == wq.size() - 1);
      exp_wr.push_back(b);
    end
    send_cmd(1'b1, a, LEN_W'(wq.size() - 1));
    for (int i = 0; i < stop_after; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = wq[i];
      n = 0;
      do begin
        @(negedge clk);
        hs = bus.wr_ready;
        step();
        n++;
      end while (!hs && n < 50);
      if (!hs) chk("wr_timeout", 0, 1);
      if (i == gap_after) begin
        bus.wr_valid = 1'b0;
        repeat (gap_len) step();
      end
    end
    if (stop_after < wq.size()) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = wq[stop_after];
    end else begin
      bus.wr_valid = 1'b0;
    end
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0,1,0,0...
  task automatic read_burst(input logic [ADDR_W-1:0] a, input int n, input int mode,
                            input bit chk_timing);
    beat_t b;
    int got;
    int c;
    for (int i = 0; i < n; i++) begin
      b.addr = a + ADDR_W'(i);
      b.data = sh(b.addr);
      b.last = (i == n - 1);
      exp_rd.push_back(b);
    end
    send_cmd(1'b0, a, LEN_W'(n - 1));
    got = 0;
    c = 0;
    while (got < n && c < 200) begin
      c++;
      bus.rd_ready = (mode == 0) ? 1'b1 : (c % 3 == 1);
      @(negedge clk);
      if (chk_timing) begin
        if (c == 1) chk("rd_first_latency", bus.rd_valid, 0);
        else if (c <= n + 1) chk("rd_stream", bus.rd_valid, 1);
      end
      if (bus.rd_valid && bus.rd_ready) got++;
      step();
    end
    bus.rd_ready = 1'b0;
    if (got < n) chk("rd_timeout", got, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    int dc0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    // Reset held with a command offered
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_mem_we", bus.mem_we, 0);
    end
    step();
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_wr_ready", bus.wr_ready, 0);
    chk("post_rst_mem_we", bus.mem_we, 0);
    chk("post_rst_mem_addr", bus.mem_addr, 0);
    chk("post_rst_rd_valid", bus.rd_valid, 0);
    chk("post_rst_rd_last", bus.rd_last, 0);
    chk("post_rst_rd_data", bus.rd_data, 0);
    chk("post_rst_done", bus.done, 0);
    step();

    // Write burst with a 2-cycle gap after beat 1
    we0 = we_cnt;
    dc0 = done_cnt;
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    write_burst(20'h00010, 1, 2, 4);
    step();
    step();
    chk("wr_beat_count", we_cnt - we0, 4);
    chk("wr_done_count", done_cnt - dc0, 1);
    chk("mem_10", mem[20'h00010], 32'hA0);
    chk("mem_11", mem[20'h00011], 32'hA1);
    chk("mem_12", mem[20'h00012], 32'hA2);
    chk("mem_13", mem[20'h00013], 32'hA3);

    // Read back, full throughput
    dc0 = done_cnt;
    read_burst(20'h00010, 4, 0, 1'b1);
    step();
    chk("rd_done_count", done_cnt - dc0, 1);

    // Read back under backpressure
    read_burst(20'h00010, 4, 1, 1'b0);
    step();

    // Address wrap
    wq = '{32'h11, 32'h22};
    write_burst(20'hFFFFF, -1, 0, 2);
    step();
    step();
    chk("mem_fffff", mem[20'hFFFFF], 32'h11);
    chk("mem_00000", mem[20'h00000], 32'h22);
    read_burst(20'hFFFFF, 2, 0, 1'b0);
    step();

    // Reset mid-burst after 3 beats, with the 4th beat still offered
    we0 = we_cnt;
    dc0 = done_cnt;
    wq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7};
    write_burst(20'h00100, -1, 0, 3);
    rst = 1'b0;
    step();
    step();
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    step();
    chk("mid_rst_write_count", we_cnt - we0, 3);
    chk("mid_rst_done_count", done_cnt - dc0, 0);
    chk("mem_100", mem[20'h00100], 32'hB0);
    chk("mem_102", mem[20'h00102], 32'hB2);
    read_burst(20'h00100, 3, 0, 1'b1);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
